accu_sequencer: RTL and testbench
=================================

ACCU_SEQUENCER -- requirements
Module: accu_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, ports CLK and RST.
REQ-002 SHALL have ports as follows (name  direction  width  meaning):
  CLK  in  1  clock, all state on rising edge
  RST  in  1  asynchronous active-high reset
  START  in  1  run request; honoured in IDLE/HALT only
  PROG_ADDR  out  8  program memory address (=PC)
  PROG_DATA  in  16  instruction, valid one cycle after PROG_ADDR
  RAM_ADDR  out  8  data RAM address
  RAM_WE  out  1  data RAM write strobe
  RAM_WDATA  out  8  data RAM write data
  ACCUMULATOR  in  8  current accumulator value
  ACCUA_WE  out  1  accumulator write enable
  ACCUA_OPCode  out  2  source select: 00 immediate, 01 RAM, 10 ALU
  ACCUA_ArgToSet  out  8  immediate operand
  ALU_OPCode  out  4  ALU operation select
  BUSY  out  1  high in every state except IDLE/HALT
  HALTED  out  1  high in HALT
  ERR  out  1  sticky illegal-opcode flag

Function
REQ-003 SHALL decode instruction as [15:12] opcode, [11:8] ALU op, [7:0] immediate/address.
REQ-004 SHALL support opcodes 0 NOP, 1 LDI, 2 LD, 3 ALU, 4 ST, 5 JMP, 6 JZ, F HALT; 7..E illegal.
REQ-005 SHALL implement states IDLE, FETCH, DECODE, WAIT, WB, HALT.
REQ-006 IDLE/HALT + START=1 -> PC=0, ERR=0, next FETCH.
REQ-007 FETCH: PROG_ADDR=PC, next DECODE unconditionally.
REQ-008 DECODE: instruction taken from PROG_DATA and latched into IR.
REQ-009 LDI in DECODE: ACCUA_WE=1, ACCUA_OPCode=00, ACCUA_ArgToSet=imm, PC+1, next FETCH (2 cycles/instr).
REQ-010 LD in DECODE: RAM_ADDR=addr, next WAIT; WAIT -> WB; WB: ACCUA_WE=1, ACCUA_OPCode=01, PC+1, next FETCH (4 cycles).
REQ-011 ALU in DECODE: ALU_OPCode=IR[11:8] held through WAIT and WB; WB: ACCUA_WE=1, ACCUA_OPCode=10 (4 cycles).
REQ-012 ST in DECODE: RAM_WE=1, RAM_ADDR=addr, RAM_WDATA=ACCUMULATOR, PC+1, next FETCH.
REQ-013 JMP: PC=addr; JZ: PC=addr if ACCUMULATOR==0 else PC+1; NOP: PC+1; all next FETCH.
REQ-014 HALT opcode -> HALT; illegal opcode -> ERR=1, HALT.
REQ-015 PC SHALL be 8 bits and wrap 0xFF -> 0x00 on increment.
REQ-016 ACCUA_WE and RAM_WE SHALL be single-cycle pulses, never both high in one cycle.
REQ-017 START while BUSY SHALL be ignored.
REQ-018 RAM_ADDR SHALL hold the LD address through WAIT and WB; outputs not listed for a state SHALL be 0.

Reset
REQ-019 RST SHALL immediately force state IDLE, PC=0, IR=0, ERR=0, all strobes 0, BUSY=0, HALTED=0.
REQ-020 RST mid-instruction SHALL abort it with no accumulator or RAM write.

Structure
REQ-021 Opcode constants, state encoding and ACCUA source-select codes SHALL live in shared package plc_pkg.
REQ-022 Combinational instruction decode SHALL be one sub-module, accu_seq_decode; FSM and PC stay in accu_sequencer.

Verification
REQ-023 Program {1_0_2A, F_0_00}, START -> ACCUA_WE pulse with opcode 00 and arg 0x2A in cycle 3, then HALTED=1, ERR=0.
REQ-024 Program {2_0_10, 4_0_11, F}, ACCUMULATOR=0x55 -> RAM_ADDR=0x10 held 3 cycles, ACCUA_WE opcode 01 in WB; RAM_WE=1, RAM_ADDR=0x11, RAM_WDATA=0x55.
REQ-025 JZ 0x20 with ACCUMULATOR=0 -> next PROG_ADDR=0x20; with ACCUMULATOR=1 -> PC+1.
REQ-026 Opcode 0x9 at PC=3 -> ERR=1, HALTED=1; START -> ERR=0, PROG_ADDR=0.
REQ-027 JMP 0xFF then NOP at 0xFF -> PROG_ADDR 0x00 next; RST asserted during WAIT of ALU -> no ACCUA_WE, state IDLE.

Source files
------------

// File: rtl/plc_pkg.sv
// Shared constants for the accumulator sequencer: opcodes, FSM states and
// accumulator source-select codes.
package plc_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int DATA_W  = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ALU  = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] SRC_IMM = 2'b00;
  localparam logic [1:0] SRC_RAM = 2'b01;
  localparam logic [1:0] SRC_ALU = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WAIT,
    S_WB,
    S_HALT
  } state_e;

  // Opcodes 7..E have no meaning and must trap.
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_JZ) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/accu_sequencer_if.sv
// Bus between the sequencer and its program memory, data RAM, accumulator
// and ALU. The master side is the sequencer.
interface accu_sequencer_if;

  logic                               START;
  logic [plc_pkg::PC_W-1:0]           PROG_ADDR;
  logic [plc_pkg::INSTR_W-1:0]        PROG_DATA;
  logic [plc_pkg::DATA_W-1:0]         RAM_ADDR;
  logic                               RAM_WE;
  logic [plc_pkg::DATA_W-1:0]         RAM_WDATA;
  logic [plc_pkg::DATA_W-1:0]         ACCUMULATOR;
  logic                               ACCUA_WE;
  logic [1:0]                         ACCUA_OPCode;
  logic [plc_pkg::DATA_W-1:0]         ACCUA_ArgToSet;
  logic [3:0]                         ALU_OPCode;
  logic                               BUSY;
  logic                               HALTED;
  logic                               ERR;

  modport master (
    input  START, PROG_DATA, ACCUMULATOR,
    output PROG_ADDR, RAM_ADDR, RAM_WE, RAM_WDATA, ACCUA_WE, ACCUA_OPCode,
           ACCUA_ArgToSet, ALU_OPCode, BUSY, HALTED, ERR
  );

  modport slave (
    output START, PROG_DATA, ACCUMULATOR,
    input  PROG_ADDR, RAM_ADDR, RAM_WE, RAM_WDATA, ACCUA_WE, ACCUA_OPCode,
           ACCUA_ArgToSet, ALU_OPCode, BUSY, HALTED, ERR
  );

endinterface

// File: rtl/accu_seq_decode.sv
// Combinational instruction field split: [15:12] opcode, [11:8] ALU op,
// [7:0] immediate/address, plus an illegal-opcode flag.
module accu_seq_decode
  import plc_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output logic [3:0]         o_opcode,
  output logic [3:0]         o_alu_op,
  output logic [DATA_W-1:0]  o_arg,
  output logic               o_illegal
);

  assign o_opcode  = i_instr[15:12];
  assign o_alu_op  = i_instr[11:8];
  assign o_arg     = i_instr[7:0];
  assign o_illegal = !op_legal(i_instr[15:12]);

endmodule

// File: rtl/accu_sequencer.sv
// Accumulator-machine sequencer: fetches 16-bit instructions, drives the
// accumulator/RAM/ALU controls and owns the PC and error flag.
module accu_sequencer
  import plc_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  accu_sequencer_if.master  bus
);

  state_e               r_state, w_next;
  logic [PC_W-1:0]      r_pc, w_pc_next, w_pc_inc;
  logic [INSTR_W-1:0]   r_ir, w_ir_next, w_instr;
  logic                 r_err, w_err_next;

  logic [3:0]           w_opcode, w_alu_op;
  logic [DATA_W-1:0]    w_arg;
  logic                 w_illegal;

  logic [DATA_W-1:0]    w_ram_addr, w_ram_wdata, w_acc_arg;
  logic                 w_ram_we, w_acc_we;
  logic [1:0]           w_acc_sel;
  logic [3:0]           w_alu_sel;

  // In DECODE the instruction comes straight off the memory bus; later
  // states of a multi-cycle instruction work from the latched copy.
  assign w_instr  = (r_state == S_DECODE) ? bus.PROG_DATA : r_ir;
  assign w_pc_inc = r_pc + 8'd1;

  accu_seq_decode u_decode (
    .i_instr   (w_instr),
    .o_opcode  (w_opcode),
    .o_alu_op  (w_alu_op),
    .o_arg     (w_arg),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pc_next   = r_pc;
    w_ir_next   = r_ir;
    w_err_next  = r_err;
    w_ram_addr  = '0;
    w_ram_we    = 1'b0;
    w_ram_wdata = '0;
    w_acc_we    = 1'b0;
    w_acc_sel   = SRC_IMM;
    w_acc_arg   = '0;
    w_alu_sel   = '0;
    unique case (r_state)
      S_IDLE, S_HALT: begin
        if (bus.START) begin
          w_pc_next  = '0;
          w_err_next = 1'b0;
          w_next     = S_FETCH;
        end
      end
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        w_ir_next = bus.PROG_DATA;
        w_next    = S_FETCH;
        if (w_illegal) begin
          w_err_next = 1'b1;
          w_next     = S_HALT;
        end else begin
          case (w_opcode)
            OP_LDI: begin
              w_acc_we  = 1'b1;
              w_acc_sel = SRC_IMM;
              w_acc_arg = w_arg;
              w_pc_next = w_pc_inc;
            end
            OP_LD: begin
              w_ram_addr = w_arg;
              w_next     = S_WAIT;
            end
            OP_ALU: begin
              w_alu_sel = w_alu_op;
              w_next    = S_WAIT;
            end
            OP_ST: begin
              w_ram_we    = 1'b1;
              w_ram_addr  = w_arg;
              w_ram_wdata = bus.ACCUMULATOR;
              w_pc_next   = w_pc_inc;
            end
            OP_JMP:  w_pc_next = w_arg;
            OP_JZ:   w_pc_next = (bus.ACCUMULATOR == 8'd0) ? w_arg : w_pc_inc;
            OP_HALT: w_next    = S_HALT;
            default: w_pc_next = w_pc_inc;
          endcase
        end
      end
      S_WAIT, S_WB: begin
        // Address/ALU select stay stable until the accumulator captures.
        if (w_opcode == OP_LD) w_ram_addr = w_arg;
        else                   w_alu_sel  = w_alu_op;
        if (r_state == S_WAIT) begin
          w_next = S_WB;
        end else begin
          w_acc_we  = 1'b1;
          w_acc_sel = (w_opcode == OP_LD) ? SRC_RAM : SRC_ALU;
          w_pc_next = w_pc_inc;
          w_next    = S_FETCH;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.PROG_ADDR      = r_pc;
  assign bus.RAM_ADDR       = w_ram_addr;
  assign bus.RAM_WE         = w_ram_we;
  assign bus.RAM_WDATA      = w_ram_wdata;
  assign bus.ACCUA_WE       = w_acc_we;
  assign bus.ACCUA_OPCode   = w_acc_sel;
  assign bus.ACCUA_ArgToSet = w_acc_arg;
  assign bus.ALU_OPCode     = w_alu_sel;
  assign bus.BUSY           = (r_state != S_IDLE) && (r_state != S_HALT);
  assign bus.HALTED         = (r_state == S_HALT);
  assign bus.ERR            = r_err;

endmodule

// File: tb/tb_accu_sequencer.sv
// Directed bench for accu_sequencer with a synchronous-read program memory.
module tb_accu_sequencer;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  accu_sequencer_if bus ();

  accu_sequencer dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  logic [15:0] mem [256];
  always @(posedge CLK) bus.PROG_DATA <= mem[bus.PROG_ADDR];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic start_run();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 64; i++) begin
      if (bus.HALTED) break;
      tick();
    end
    check(tag, 16'(bus.HALTED), 16'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    bus.START       = 1'b0;
    bus.ACCUMULATOR = 8'h00;
    fill_halt();

    // Reset state
    tick();
    check("rst_busy",   16'(bus.BUSY),      16'h0);
    check("rst_halted", 16'(bus.HALTED),    16'h0);
    check("rst_err",    16'(bus.ERR),       16'h0);
    check("rst_accwe",  16'(bus.ACCUA_WE),  16'h0);
    check("rst_ramwe",  16'(bus.RAM_WE),    16'h0);
    check("rst_paddr",  16'(bus.PROG_ADDR), 16'h0);
    RST = 1'b0;
    tick();
    check("idle_busy",  16'(bus.BUSY),      16'h0);

    // LDI 0x2A then HALT
    mem[0] = 16'h102A;
    start_run();
    check("ldi_fetch_addr", 16'(bus.PROG_ADDR), 16'h0);
    check("ldi_fetch_busy", 16'(bus.BUSY),      16'h1);
    check("ldi_fetch_we",   16'(bus.ACCUA_WE),  16'h0);
    tick();
    check("ldi_we",   16'(bus.ACCUA_WE),       16'h1);
    check("ldi_sel",  16'(bus.ACCUA_OPCode),   16'h0);
    check("ldi_arg",  16'(bus.ACCUA_ArgToSet), 16'h2A);
    tick();
    check("ldi_we_pulse", 16'(bus.ACCUA_WE),  16'h0);
    check("ldi_next_pc",  16'(bus.PROG_ADDR), 16'h1);
    tick();
    tick();
    check("ldi_halted", 16'(bus.HALTED), 16'h1);
    check("ldi_err",    16'(bus.ERR),    16'h0);
    check("ldi_busy",   16'(bus.BUSY),   16'h0);

    // LD 0x10, ST 0x11, HALT
    fill_halt();
    mem[0] = 16'h2010;
    mem[1] = 16'h4011;
    bus.ACCUMULATOR = 8'h55;
    start_run();
    tick();
    check("ld_dec_addr",  16'(bus.RAM_ADDR), 16'h10);
    check("ld_dec_accwe", 16'(bus.ACCUA_WE), 16'h0);
    check("ld_dec_ramwe", 16'(bus.RAM_WE),   16'h0);
    tick();
    check("ld_wait_addr",  16'(bus.RAM_ADDR), 16'h10);
    check("ld_wait_accwe", 16'(bus.ACCUA_WE), 16'h0);
    tick();
    check("ld_wb_addr",  16'(bus.RAM_ADDR),     16'h10);
    check("ld_wb_accwe", 16'(bus.ACCUA_WE),     16'h1);
    check("ld_wb_sel",   16'(bus.ACCUA_OPCode), 16'h1);
    check("ld_wb_ramwe", 16'(bus.RAM_WE),       16'h0);
    tick();
    check("ld_next_pc",  16'(bus.PROG_ADDR), 16'h1);
    check("ld_fetch_we", 16'(bus.ACCUA_WE),  16'h0);
    check("ld_fetch_ra", 16'(bus.RAM_ADDR),  16'h0);
    tick();
    check("st_ramwe", 16'(bus.RAM_WE),    16'h1);
    check("st_addr",  16'(bus.RAM_ADDR),  16'h11);
    check("st_wdata", 16'(bus.RAM_WDATA), 16'h55);
    check("st_accwe", 16'(bus.ACCUA_WE),  16'h0);
    tick();
    check("st_we_pulse", 16'(bus.RAM_WE),    16'h0);
    check("st_next_pc",  16'(bus.PROG_ADDR), 16'h2);
    wait_halt("st_halt");
    check("st_err", 16'(bus.ERR), 16'h0);

    // ALU op 5, START while busy must be ignored
    fill_halt();
    mem[0] = 16'h3500;
    start_run();
    tick();
    check("alu_dec_op", 16'(bus.ALU_OPCode), 16'h5);
    tick();
    check("alu_wait_op", 16'(bus.ALU_OPCode), 16'h5);
    check("alu_wait_we", 16'(bus.ACCUA_WE),   16'h0);
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check("alu_wb_we",   16'(bus.ACCUA_WE),     16'h1);
    check("alu_wb_sel",  16'(bus.ACCUA_OPCode), 16'h2);
    check("alu_wb_op",   16'(bus.ALU_OPCode),   16'h5);
    check("alu_wb_busy", 16'(bus.BUSY),         16'h1);
    tick();
    check("alu_next_pc",  16'(bus.PROG_ADDR),  16'h1);
    check("alu_fetch_op", 16'(bus.ALU_OPCode), 16'h0);
    wait_halt("alu_halt");

    // JZ 0x20, taken then not taken
    fill_halt();
    mem[0] = 16'h6020;
    bus.ACCUMULATOR = 8'h00;
    start_run();
    tick();
    tick();
    check("jz_taken_pc", 16'(bus.PROG_ADDR), 16'h20);
    wait_halt("jz_taken_halt");
    bus.ACCUMULATOR = 8'h01;
    start_run();
    tick();
    tick();
    check("jz_not_taken_pc", 16'(bus.PROG_ADDR), 16'h1);
    wait_halt("jz_not_taken_halt");

    // Illegal opcode at PC=3, then restart
    fill_halt();
    mem[0] = 16'h0000;
    mem[1] = 16'h0000;
    mem[2] = 16'h0000;
    mem[3] = 16'h9000;
    start_run();
    wait_halt("ill_halt");
    check("ill_err",    16'(bus.ERR),       16'h1);
    check("ill_halted", 16'(bus.HALTED),    16'h1);
    check("ill_pc",     16'(bus.PROG_ADDR), 16'h3);
    start_run();
    check("ill_restart_err",  16'(bus.ERR),       16'h0);
    check("ill_restart_pc",   16'(bus.PROG_ADDR), 16'h0);
    check("ill_restart_busy", 16'(bus.BUSY),      16'h1);
    wait_halt("ill_again_halt");
    check("ill_again_err", 16'(bus.ERR), 16'h1);

    // JMP 0xFF then NOP at 0xFF wraps to 0x00
    fill_halt();
    mem[0]   = 16'h50FF;
    mem[255] = 16'h0000;
    start_run();
    tick();
    tick();
    check("jmp_pc", 16'(bus.PROG_ADDR), 16'hFF);
    tick();
    tick();
    check("wrap_pc", 16'(bus.PROG_ADDR), 16'h0);
    RST = 1'b1;
    #1;
    check("jmp_rst_busy", 16'(bus.BUSY), 16'h0);
    tick();
    RST = 1'b0;

    // Reset during WAIT of an ALU instruction
    fill_halt();
    mem[0] = 16'h3A00;
    start_run();
    tick();
    tick();
    check("abort_wait_op", 16'(bus.ALU_OPCode), 16'hA);
    RST = 1'b1;
    #1;
    check("abort_now_we",   16'(bus.ACCUA_WE),   16'h0);
    check("abort_now_busy", 16'(bus.BUSY),       16'h0);
    check("abort_now_op",   16'(bus.ALU_OPCode), 16'h0);
    tick();
    check("abort_we",     16'(bus.ACCUA_WE),  16'h0);
    check("abort_halted", 16'(bus.HALTED),    16'h0);
    check("abort_pc",     16'(bus.PROG_ADDR), 16'h0);
    RST = 1'b0;
    tick();
    check("abort_idle_busy", 16'(bus.BUSY),     16'h0);
    check("abort_idle_we",   16'(bus.ACCUA_WE), 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
